// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction-memory write port out
interface imem_loader_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: header + little-endian words into instruction memory
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       MEM_WORDS     = 256,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = ADDRESS_WIDTH'(32'hBFC00000)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;

  // Where a load ends once the payload (or an empty header) is complete.
  localparam state_t END_STATE =
`ifdef LOADER_CHECKSUM_EN
    CSUM;
`else
    DONE;
`endif

  localparam logic [16:0] MAX_WORDS = 17'(MEM_WORDS);

  state_t                   state, state_next;
  logic [15:0]              word_count, count_next;
  logic [15:0]              word_idx, idx_next;
  logic [1:0]               byte_idx, bidx_next;
  logic [7:0]               csum, csum_next;
  logic [31:0]              word_buf, buf_next;
  logic                     wr_en_q, wr_en_next;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, addr_next;
  logic [DATA_WIDTH-1:0]    wr_data_q, data_next;

  logic        ready;
  logic        accept;
  logic [15:0] hdr_count;
  logic [31:0] assembled;

  assign ready     = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CSUM);
  assign accept    = bus.byte_valid && ready;
  assign hdr_count = {bus.byte_data, word_count[7:0]};
  assign assembled = {bus.byte_data, word_buf[31:8]};

  assign bus.byte_ready = ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign cpu_hold       = ready || (state == ERR);
  assign done           = (state == DONE);
  assign error          = (state == ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      word_count <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      word_buf   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state      <= state_next;
      word_count <= count_next;
      word_idx   <= idx_next;
      byte_idx   <= bidx_next;
      csum       <= csum_next;
      word_buf   <= buf_next;
      wr_en_q    <= wr_en_next;
      wr_addr_q  <= addr_next;
      wr_data_q  <= data_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = word_count;
    idx_next   = word_idx;
    bidx_next  = byte_idx;
    csum_next  = csum;
    buf_next   = word_buf;
    wr_en_next = 1'b0;
    addr_next  = wr_addr_q;
    data_next  = wr_data_q;

    // start wins over any byte accepted in the same cycle, discarding it.
    if (start) begin
      state_next = HDR0;
      count_next = '0;
      idx_next   = '0;
      bidx_next  = '0;
      csum_next  = '0;
      buf_next   = '0;
    end else if (accept) begin
      case (state)
        HDR0: begin
          count_next = {8'h00, bus.byte_data};
          state_next = HDR1;
        end
        HDR1: begin
          count_next = hdr_count;
          if (hdr_count == 16'd0)
            state_next = END_STATE;
          else if ({1'b0, hdr_count} > MAX_WORDS)
            state_next = ERR;
          else
            state_next = DATA;
        end
        DATA: begin
          buf_next  = assembled;
          csum_next = csum ^ bus.byte_data;
          bidx_next = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            wr_en_next = 1'b1;
            addr_next  = BASE_ADDR + ADDRESS_WIDTH'({word_idx, 2'b00});
            data_next  = DATA_WIDTH'(assembled);
            idx_next   = word_idx + 16'd1;
            if (word_idx + 16'd1 == word_count)
              state_next = END_STATE;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: state_next = (bus.byte_data == csum) ? DONE : ERR;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'hBFC00000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, error;

  imem_loader_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

  imem_loader #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_WORDS(256), .BASE_ADDR(32'hBFC00000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.slave),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst && bus.wr_en) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", bus.wr_addr, e.addr);
        check("wr_data", bus.wr_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %h not accepted within 20 cycles", b);
    end
    tick();
    bus.byte_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) send_byte(bytes[i], gap);
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset held, then released with no start.
    repeat (3) tick();
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_byte_ready", bus.byte_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    rst = 1'b1;
    repeat (5) tick();
    check("idle_cpu_hold", cpu_hold, 0);
    check("idle_byte_ready", bus.byte_ready, 0);
    check("idle_done", done, 0);
    check("idle_error", error, 0);

    // Two-word load, back-to-back bytes.
    exp_q.push_back('{BASE, 32'h00A00513});
    exp_q.push_back('{BASE + 32'd4, 32'h00100593});
    pulse_start();
    check("hdr_cpu_hold", cpu_hold, 1);
    check("hdr_byte_ready", bus.byte_ready, 1);
    pl = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send_bytes(pl, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h30, 0);
`endif
    tick();
    wait_drain("load2_drain");
    check("load2_done", done, 1);
    check("load2_cpu_hold", cpu_hold, 0);
    check("load2_error", error, 0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hFF;
    repeat (4) tick();
    bus.byte_valid = 1'b0;
    check("done_ignores_bytes", done, 1);
    check("done_byte_ready", bus.byte_ready, 0);

    // Oversized header.
    pulse_start();
    check("restart_done_clear", done, 0);
    pl = {8'h01, 8'h01};
    send_bytes(pl, 0);
    tick();
    check("big_error", error, 1);
    check("big_cpu_hold", cpu_hold, 1);
    check("big_done", done, 0);
    check("big_byte_ready", bus.byte_ready, 0);

    // Restart mid-payload, then empty load.
    pulse_start();
    check("restart_error_clear", error, 0);
    pl = {8'h01, 8'h00, 8'hAA, 8'hBB};
    send_bytes(pl, 0);
    pulse_start();
    pl = {8'h00, 8'h00};
    send_bytes(pl, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    tick();
    check("empty_done", done, 1);
    check("empty_error", error, 0);

    // start coincident with a valid byte: that byte must be dropped.
    pulse_start();
    pl = {8'h01, 8'h00, 8'h11, 8'h22};
    send_bytes(pl, 0);
    start = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h33;
    tick();
    start = 1'b0;
    bus.byte_valid = 1'b0;
    exp_q.push_back('{BASE, 32'h77665544});
    pl = {8'h01, 8'h00, 8'h44, 8'h55, 8'h66, 8'h77};
    send_bytes(pl, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    tick();
    wait_drain("coincide_drain");
    check("coincide_done", done, 1);

    // Full MEM_WORDS load: last address BASE + 0x3FC.
    for (int k = 0; k < 256; k++) begin
      logic [7:0] b0;
      b0 = 8'(k * 4);
      exp_q.push_back('{BASE + 32'(k * 4), {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}});
    end
    pulse_start();
    pl = {8'h00, 8'h01};
    send_bytes(pl, 0);
    for (int i = 0; i < 1024; i++) send_byte(8'(i), 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    tick();
    wait_drain("full_drain");
    check("full_done", done, 1);

    // Stalls every other cycle during payload.
    exp_q.push_back('{BASE, 32'h00A00513});
    exp_q.push_back('{BASE + 32'd4, 32'h00100593});
    pulse_start();
    pl = {8'h02, 8'h00};
    send_bytes(pl, 0);
    pl = {8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send_bytes(pl, 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h30, 1);
`endif
    tick();
    wait_drain("stall_drain");
    check("stall_done", done, 1);

    // Reset mid-word abandons the load immediately.
    pulse_start();
    pl = {8'h01, 8'h00, 8'hDE, 8'hAD};
    send_bytes(pl, 0);
    rst = 1'b0;
    #1;
    check("async_byte_ready", bus.byte_ready, 0);
    check("async_cpu_hold", cpu_hold, 0);
    check("async_done", done, 0);
    check("async_error", error, 0);
    tick();
    tick();
    rst = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hBE;
    repeat (6) tick();
    bus.byte_valid = 1'b0;
    check("post_rst_cpu_hold", cpu_hold, 0);
    check("post_rst_byte_ready", bus.byte_ready, 0);
    check("post_rst_done", done, 0);

`ifdef LOADER_CHECKSUM_EN
    exp_q.push_back('{BASE, 32'h04030201});
    pulse_start();
    pl = {8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_bytes(pl, 0);
    tick();
    wait_drain("csum_bad_drain");
    check("csum_bad_error", error, 1);
    check("csum_bad_done", done, 0);
    exp_q.push_back('{BASE, 32'h04030201});
    pulse_start();
    pl = {8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_bytes(pl, 0);
    tick();
    wait_drain("csum_good_drain");
    check("csum_good_done", done, 1);
    check("csum_good_error", error, 0);
`endif

    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
